// File: rtl/ysyx_25020037_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read path (AR/R) between the fetch
// unit (master 0) and the LSU (master 1); one transaction in flight at a time.
module ysyx_25020037_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_araddr,
  input  logic          m0_arvalid,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  input  logic [AW-1:0] m1_araddr,
  input  logic          m1_arvalid,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  output logic [AW-1:0] s_araddr,
  output logic          s_arvalid,
  input  logic          s_arready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rvalid,
  output logic          s_rready,
  output logic          busy,
  output logic          grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   sel_arvalid;
  logic   sel_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // fetch wins the first tie
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign sel_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign sel_rready  = grant_q ? m1_rready  : m0_rready;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_araddr     = '0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    m0_rresp     = 2'b00;
    m1_rresp     = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Requests only steer the registered grant; nothing reaches the slave this cycle.
        if (m0_arvalid && m1_arvalid) begin
          grant_d = ~last_grant_q;
          state_d = ADDR;
        end else if (m0_arvalid) begin
          grant_d = 1'b0;
          state_d = ADDR;
        end else if (m1_arvalid) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        s_araddr  = grant_q ? m1_araddr : m0_araddr;
        s_arvalid = sel_arvalid;
        if (grant_q) m1_arready = s_arready;
        else         m0_arready = s_arready;
        if (sel_arvalid && s_arready) state_d = DATA;
        else if (!sel_arvalid)        state_d = IDLE;
      end

      DATA: begin
        s_rready = sel_rready;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && sel_rready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_ysyx_25020037_rd_arbiter.sv
// Directed self-checking bench for the two-master AXI4-Lite read arbiter.
module tb_ysyx_25020037_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]    m0_rresp, m1_rresp, s_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic          busy, grant;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25020037_rd_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and land 2ns after the edge, away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet_inputs();
    m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    quiet_inputs();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b required=0", busy); end
    n_checks++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant got=%0b required=0", grant); end
    n_checks++; if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0) begin n_fail++; $display("FAIL reset_handshakes got=%b required=000000", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}); end
    n_checks++; if (s_araddr !== 32'h0) begin n_fail++; $display("FAIL reset_s_araddr got=%h required=00000000", s_araddr); end
  endtask

  task automatic test_single_fetch();
    quiet_inputs();
    do_reset();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
    #1;
    n_checks++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL idle_no_comb_arvalid got=%0b required=0", s_arvalid); end
    n_checks++; if (m0_arready !== 1'b0) begin n_fail++; $display("FAIL idle_m0_arready got=%0b required=0", m0_arready); end
    step();
    n_checks++; if (s_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL single_s_araddr got=%h required=80000000", s_araddr); end
    n_checks++; if ({busy, grant, s_arvalid, m0_arready, m0_rvalid, s_rready} !== 6'b101100) begin n_fail++; $display("FAIL single_addr_flags got=%b required=101100", {busy, grant, s_arvalid, m0_arready, m0_rvalid, s_rready}); end
    step();
    m0_arvalid = 1'b0;
    #1;
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL single_m0_data got=%0b/%h required=1/00000413", m0_rvalid, m0_rdata); end
    n_checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL single_m1_quiet got=%0b/%h required=0/00000000", m1_rvalid, m1_rdata); end
    n_checks++; if (s_rready !== 1'b1) begin n_fail++; $display("FAIL single_s_rready got=%0b required=1", s_rready); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_back_idle got=%0b required=0", busy); end
  endtask

  task automatic test_round_robin();
    logic          exp_g;
    logic [31:0]   exp_addr;
    logic [31:0]   exp_data;
    quiet_inputs();
    do_reset();
    m0_araddr = 32'h8000_0004; m1_araddr = 32'h8000_1000;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g    = (i % 2) == 1;
      exp_addr = exp_g ? 32'h8000_1000 : 32'h8000_0004;
      exp_data = 32'hA000_0000 + 32'(i);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr%0d_idle_busy got=%0b required=0", i, busy); end
      step();
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr%0d_grant got=%0b required=%0b", i, grant, exp_g); end
      n_checks++; if (s_araddr !== exp_addr) begin n_fail++; $display("FAIL rr%0d_s_araddr got=%h required=%h", i, s_araddr, exp_addr); end
      n_checks++; if ({m1_arready, m0_arready} !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr%0d_arready got=%b required=%b", i, {m1_arready, m0_arready}, (exp_g ? 2'b10 : 2'b01)); end
      step();
      s_rdata = exp_data;
      #1;
      n_checks++; if ({m1_rvalid, m0_rvalid} !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr%0d_rvalid got=%b required=%b", i, {m1_rvalid, m0_rvalid}, (exp_g ? 2'b10 : 2'b01)); end
      n_checks++; if ((exp_g ? m1_rdata : m0_rdata) !== exp_data || (exp_g ? m0_rdata : m1_rdata) !== 32'h0) begin n_fail++; $display("FAIL rr%0d_rdata got=%h/%h required=%h to owner only", i, m0_rdata, m1_rdata, exp_data); end
      step();
    end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    step();
  endtask

  task automatic test_slow_slave_hold_off();
    quiet_inputs();
    do_reset();
    m0_araddr = 32'h8000_0008; m0_arvalid = 1'b1; s_arready = 1'b1;
    m1_araddr = 32'h8000_2000;
    step();
    m1_arvalid = 1'b1;
    step();
    m0_arvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if ({busy, m1_arready, m0_rvalid} !== 3'b100) begin n_fail++; $display("FAIL slow_wait%0d got=%b required=100", c, {busy, m1_arready, m0_rvalid}); end
      step();
    end
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    n_checks++; if ({busy, m1_arready, m0_rvalid, m1_rvalid} !== 4'b1010) begin n_fail++; $display("FAIL slow_rhs got=%b required=1010", {busy, m1_arready, m0_rvalid, m1_rvalid}); end
    step();
    s_rvalid = 1'b0;
    #1;
    n_checks++; if ({busy, m1_arready} !== 2'b00) begin n_fail++; $display("FAIL slow_idle got=%b required=00", {busy, m1_arready}); end
    step();
    n_checks++; if ({grant, m1_arready, m0_arready} !== 3'b110 || s_araddr !== 32'h8000_2000) begin n_fail++; $display("FAIL slow_m1_granted got=%b/%h required=110/80002000", {grant, m1_arready, m0_arready}, s_araddr); end
    step();
    m1_arvalid = 1'b0; s_rvalid = 1'b1;
    step();
  endtask

  task automatic test_rready_backpressure();
    quiet_inputs();
    do_reset();
    m0_araddr = 32'h8000_000C; m0_arvalid = 1'b1; s_arready = 1'b1;
    step();
    step();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001; m0_rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({busy, s_rready, m0_rvalid} !== 3'b101) begin n_fail++; $display("FAIL bp_hold%0d got=%b required=101", c, {busy, s_rready, m0_rvalid}); end
      step();
    end
    m0_rready = 1'b1;
    #1;
    n_checks++; if (s_rready !== 1'b1 || m0_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL bp_release got=%0b/%h required=1/cafe0001", s_rready, m0_rdata); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_done got=%0b required=0", busy); end
  endtask

  task automatic test_slverr();
    quiet_inputs();
    do_reset();
    m1_araddr = 32'h1000_0000; m1_arvalid = 1'b1; s_arready = 1'b1;
    step();
    n_checks++; if (grant !== 1'b1) begin n_fail++; $display("FAIL err_grant got=%0b required=1", grant); end
    step();
    m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rresp = 2'b10; s_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if ({m1_rvalid, m1_rresp} !== 3'b110) begin n_fail++; $display("FAIL err_m1_resp got=%b required=110", {m1_rvalid, m1_rresp}); end
    n_checks++; if ({m0_rvalid, m0_rresp} !== 3'b000) begin n_fail++; $display("FAIL err_m0_quiet got=%b required=000", {m0_rvalid, m0_rresp}); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_back_idle got=%0b required=0", busy); end
  endtask

  task automatic test_abort();
    quiet_inputs();
    do_reset();
    m0_araddr = 32'h8000_0010; m0_arvalid = 1'b1;
    step();
    n_checks++; if ({s_arvalid, m0_arready} !== 2'b10) begin n_fail++; $display("FAIL abort_stall got=%b required=10", {s_arvalid, m0_arready}); end
    m0_arvalid = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got=%0b required=0", busy); end
  endtask

  task automatic test_reset_mid_data();
    quiet_inputs();
    do_reset();
    m1_araddr = 32'h2000_0000; m1_arvalid = 1'b1; s_arready = 1'b1;
    step();
    step();
    m1_arvalid = 1'b0;
    #1;
    n_checks++; if ({busy, grant} !== 2'b11) begin n_fail++; $display("FAIL rstd_in_data got=%b required=11", {busy, grant}); end
    rst = 1'b1; s_rvalid = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if ({busy, grant} !== 2'b00) begin n_fail++; $display("FAIL rstd_state got=%b required=00", {busy, grant}); end
    n_checks++; if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0 || s_araddr !== 32'h0) begin n_fail++; $display("FAIL rstd_outputs got=%b/%h required=000000/00000000", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, s_araddr); end
    s_rvalid = 1'b0;
    m0_araddr = 32'h8000_0020; m0_arvalid = 1'b1;
    step();
    n_checks++; if ({grant, s_arvalid} !== 2'b01 || s_araddr !== 32'h8000_0020) begin n_fail++; $display("FAIL rstd_after_addr got=%b/%h required=01/80000020", {grant, s_arvalid}, s_araddr); end
    step();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL rstd_after_data got=%0b/%h required=1/5555aaaa", m0_rvalid, m0_rdata); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstd_after_idle got=%0b required=0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_slow_slave_hold_off();
    test_rready_backpressure();
    test_slverr();
    test_abort();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_rd_arbiter.md
Name: ysyx_25020037_rd_arbiter

Overview:
- Two-requester arbiter for the single AXI4-Lite read path (AR and R channels) to memory.
- Master 0 is the instruction fetch unit; master 1 is the load/store unit.
- Exactly one transaction is outstanding at a time. Grant is round-robin, so fetch and load traffic cannot starve each other.
- Sits between the core fetch/LSU read ports and the memory/SRAM slave.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- m0_araddr  in  AW  fetch read address.
- m0_arvalid  in  1  fetch address valid.
- m0_arready  out  1  fetch address accepted.
- m0_rdata  out  DW  fetch read data.
- m0_rresp  out  2  fetch read response.
- m0_rvalid  out  1  fetch data valid.
- m0_rready  in  1  fetch ready for data.
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready: same widths and meanings, for the LSU.
- s_araddr  out  AW  address to slave.
- s_arvalid  out  1  address valid to slave.
- s_arready  in  1  slave accepts address.
- s_rdata  in  DW  slave data.
- s_rresp  in  2  slave response.
- s_rvalid  in  1  slave data valid.
- s_rready  out  1  ready toward slave.
- busy  out  1  1 whenever state is not IDLE.
- grant  out  1  owner index (0 = fetch, 1 = LSU); meaningful when busy is 1.

Behaviour:
- States: IDLE, ADDR, DATA. State, grant and last_grant are registers.
- Reset (rst high at a clock edge):
  - state=IDLE, grant=0, last_grant=1, so fetch wins the first tie.
  - With state=IDLE, all ready/valid outputs read 0 and s_araddr=0.
  - A reset asserted mid-transaction abandons it; no response is forwarded after reset.
- IDLE:
  - No master is granted. s_arvalid=0, s_rready=0, m*_arready=0, m*_rvalid=0.
  - If exactly one m*_arvalid is 1: grant that master and go to ADDR next cycle.
  - If both are 1: grant the master not equal to last_grant, then go to ADDR.
  - If neither is 1: stay in IDLE.
  - Arbitration costs exactly one cycle. Earliest s_arvalid is the cycle after a request first appears.
- ADDR (combinational routing from the registered grant):
  - s_araddr = m[grant]_araddr; s_arvalid = m[grant]_arvalid; m[grant]_arready = s_arready.
  - The non-granted master's arready is 0.
  - On s_arvalid && s_arready: go to DATA.
  - If the granted master drops arvalid before the handshake (protocol violation), return to IDLE without a transfer.
- DATA:
  - s_rready = m[grant]_rready; m[grant]_rvalid = s_rvalid; m[grant]_rdata = s_rdata; m[grant]_rresp = s_rresp.
  - Non-granted master: rvalid=0; rdata and rresp are driven 0.
  - On s_rvalid && s_rready: last_grant <= grant, go to IDLE.
  - rresp is passed through unmodified, including SLVERR/DECERR.
- Ordering and timing:
  - Non-granted requests are held off (arready=0) and are neither dropped nor reordered; each master keeps arvalid high until its own handshake.
  - Minimum transaction is 3 cycles for a zero-wait slave (IDLE, ADDR, DATA). Back-to-back transactions re-enter IDLE for one cycle.
- Simultaneous events: a new request arriving in the same cycle as the R handshake is seen in the following IDLE cycle. It is arbitrated with the updated last_grant.
- No combinational path exists from m*_arvalid to s_arvalid while in IDLE.

Test Plan:
- Reset, then m0 only, araddr=0x80000000, zero-wait slave returning 0x00000413 with rresp=0 → s_araddr=0x80000000 in cycle 2; m0_rvalid=1 with rdata=0x00000413 in cycle 3; m1_rvalid stays 0.
- Both masters request continuously (m0 at 0x80000004, m1 at 0x80001000) → grants alternate 0,1,0,1 over four transactions; each transaction's data reaches only its owner.
- Slave with 5-cycle R latency while m1 requests mid-transaction of m0 → m1_arready stays 0 until m0's R handshake. m1 is granted in the next IDLE cycle; busy stays 1 throughout DATA.
- m0_rready held 0 for 3 cycles while s_rvalid=1 → s_rready=0 and state stays DATA; completes on the cycle m0_rready rises.
- Slave returns rresp=2'b10 to m1 → m1_rresp=2'b10 and m1_rvalid=1; the arbiter returns to IDLE normally.
- rst pulsed during DATA → next cycle state=IDLE, busy=0, grant=0, all valid/ready outputs 0; a later m0 request completes normally.
